ram_sync_bank: RTL and testbench

//  Parametrised single-clock RAM bank for scan-buffer storage.
//  - Separate write/read data buses; no tri-state. Byte-enabled writes; 1-cycle registered read with valid strobe.
//  - Reset or clr request sweeps memory to INIT_VAL, one word per cycle; busy asserted meanwhile.
//  - Sits between the barcode decoder/capture logic and the host readout path.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_sync_bank_if.sv | 35 +++
 rtl/ram_sync_array.sv | 54 +++++
 rtl/ram_sync_bank.sv | 134 +++++++++++++
 tb/tb_ram_sync_bank.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the scan-buffer RAM bank.
//   state_e    - sweep/ready state encoding for the bank controller
//   byte_lanes - number of byte write-enable lanes for a given data width
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int byte_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ram_sync_bank_if.sv
// ram_sync_bank_if: access bus of the RAM bank.
//   master drives : cs, memw, memr, addr, wbe, wdata, clr
//   slave drives  : rdata, rvalid, busy, err
interface ram_sync_bank_if
    import ram_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 13
) ();

    localparam int NB = byte_lanes(DW);

    logic          cs;
    logic          memw;
    logic          memr;
    logic [AW-1:0] addr;
    logic [NB-1:0] wbe;
    logic [DW-1:0] wdata;
    logic          clr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;
    logic          err;

    modport master (
        output cs, memw, memr, addr, wbe, wdata, clr,
        input  rdata, rvalid, busy, err
    );

    modport slave (
        input  cs, memw, memr, addr, wbe, wdata, clr,
        output rdata, rvalid, busy, err
    );

endinterface

// File: rtl/ram_sync_array.sv
// ram_sync_array: DEPTH x DW storage, single address, byte-enabled write and
// synchronous enabled read. A read in the same cycle as a write to the same
// word returns the old contents; the caller handles write-first merging.
//   clk, rst  - clock, synchronous active-low reset (read register only)
//   we_i      - write enable;  wbe_i selects byte lanes of wdata_i
//   re_i      - read enable;   rdata_o updates only when re_i is high
//   addr_i    - word address, must be < DEPTH when we_i or re_i is high
module ram_sync_array
    import ram_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 13,
    parameter int DEPTH = 8192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [byte_lanes(DW)-1:0] wbe_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW-1:0]             rdata_o
);

    localparam int NB = byte_lanes(DW);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: storage has no reset; clearing it is the controller's sweep,
    // which keeps this a plain RAM macro rather than thousands of flops.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sync_bank.sv
// ram_sync_bank: single-clock RAM bank for scan-buffer storage.
//   clk  - clock, all logic on posedge
//   rst  - synchronous reset, active-low; starts a clear sweep
//   bus  - slave side of ram_sync_bank_if:
//          cs/memw/memr/addr/wbe/wdata access request, clr sweep request,
//          rdata/rvalid 1-cycle read result, busy during sweep, err on reject
// After reset or a clr pulse every word is written with INIT_VAL, one word per
// cycle; accesses during the sweep are rejected with err.
module ram_sync_bank
    import ram_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            AW       = 13,
    parameter int            DEPTH    = 8192,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    ram_sync_bank_if.slave    bus
);

    localparam int            NB        = byte_lanes(DW);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] clr_addr_q;
    logic          rvalid_q;
    logic          err_q;
    logic          oor_q;         // last read was out of range -> rdata 0
    logic [DW-1:0] byp_mask_q;    // bits written in the same cycle as the last read
    logic [DW-1:0] byp_data_q;

    logic          ready;
    logic          in_range;
    logic          access;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW-1:0] be_mask;

    logic          arr_we;
    logic          arr_re;
    logic [AW-1:0] arr_addr;
    logic [NB-1:0] arr_wbe;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata;

    assign ready    = (state_q == ST_READY);
    assign in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign access   = bus.cs & (bus.memw | bus.memr);
    assign wr_acc   = ready & bus.cs & bus.memw & in_range;
    assign rd_acc   = ready & bus.cs & bus.memr;

    // NOTE: every variable written in always_comb gets a default first so no
    // latch can be inferred.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be_mask[8*i +: 8] = {8{bus.wbe[i]}};
        end
    end

    // The sweep borrows the array's single write port while not ready.
    assign arr_we    = rst & (~ready | wr_acc);
    assign arr_re    = rst & rd_acc & in_range;
    assign arr_addr  = ready ? bus.addr  : clr_addr_q;
    assign arr_wbe   = ready ? bus.wbe   : '1;
    assign arr_wdata = ready ? bus.wdata : INIT_VAL;

    ram_sync_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wbe_i   (arr_wbe),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            oor_q      <= 1'b0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            rvalid_q <= rd_acc;
            err_q    <= access & (~ready | ~in_range);

            // Bypass state is captured only on reads so rdata holds otherwise.
            if (rd_acc) begin
                oor_q      <= ~in_range;
                byp_mask_q <= wr_acc ? be_mask : '0;
                byp_data_q <= bus.wdata;
            end

            case (state_q)
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ST_READY;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clr) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // Write-first: lanes written alongside the read come from the write data.
    assign bus.rdata  = oor_q ? '0 : ((arr_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q));
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.busy   = ~ready;

endmodule

// File: tb/tb_ram_sync_bank.sv
// Testbench for ram_sync_bank: directed scenarios plus randomized traffic,
// checked every cycle against a word-array reference model.
module tb_ram_sync_bank;

    localparam int            DW    = 16;
    localparam int            AW    = 4;
    localparam int            DEPTH = 12;
    localparam int            NB    = DW / 8;
    localparam logic [DW-1:0] INIT  = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ram_sync_bank_if #(.DW(DW), .AW(AW)) bus ();

    ram_sync_bank #(
        .DW       (DW),
        .AW       (AW),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    int            sweep_left = 0;
    logic [DW-1:0] rdata_m    = '0;
    logic          rvalid_m   = 1'b0;
    logic          err_m      = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic cs, input logic w, input logic r, input int a,
                         input logic [NB-1:0] be, input logic [DW-1:0] wd, input logic c);
        bus.cs    = cs;
        bus.memw  = w;
        bus.memr  = r;
        bus.addr  = AW'(a);
        bus.wbe   = be;
        bus.wdata = wd;
        bus.clr   = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    // One clock: capture inputs, advance the model by one edge, compare.
    task automatic cycle();
        logic          r_s, cs_s, w_s, rd_s, c_s;
        logic [NB-1:0] be_s;
        logic [DW-1:0] wd_s;
        int            a;
        r_s  = rst;
        cs_s = bus.cs;
        w_s  = bus.memw;
        rd_s = bus.memr;
        c_s  = bus.clr;
        be_s = bus.wbe;
        wd_s = bus.wdata;
        a    = int'(bus.addr);
        @(posedge clk);
        if (!r_s) begin
            sweep_left = DEPTH;
            rdata_m    = '0;
            rvalid_m   = 1'b0;
            err_m      = 1'b0;
        end else if (sweep_left > 0) begin
            mem_m[DEPTH - sweep_left] = INIT;
            sweep_left--;
            rvalid_m = 1'b0;
            err_m    = cs_s && (w_s || rd_s);
        end else begin
            rvalid_m = 1'b0;
            err_m    = cs_s && (w_s || rd_s) && (a >= DEPTH);
            if (cs_s && w_s && a < DEPTH) begin
                for (int i = 0; i < NB; i++) begin
                    if (be_s[i]) mem_m[a][8*i +: 8] = wd_s[8*i +: 8];
                end
            end
            if (cs_s && rd_s) begin
                rvalid_m = 1'b1;
                rdata_m  = (a < DEPTH) ? mem_m[a] : '0;
            end
            if (c_s) sweep_left = DEPTH;
        end
        #1;
        check("busy",   32'(bus.busy),   32'(sweep_left > 0));
        check("rvalid", 32'(bus.rvalid), 32'(rvalid_m));
        check("err",    32'(bus.err),    32'(err_m));
        check("rdata",  32'(bus.rdata),  32'(rdata_m));
    endtask

    // Counts cycles with busy high, bounded so a stuck sweep cannot hang the run.
    task automatic count_busy(input string tag);
        int busy_cnt;
        busy_cnt = 0;
        idle();
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
            busy_cnt++;
            cycle();
        end
        check(tag, 32'(busy_cnt), 32'(DEPTH));
    endtask

    initial begin
        idle();

        // 1. Reset for two cycles, then a full sweep; all words read as zero.
        rst = 1'b0;
        cycle();
        cycle();
        check("rst_busy",   32'(bus.busy),   32'd1);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata",  32'(bus.rdata),  32'd0);
        rst = 1'b1;
        count_busy("sweep_len");
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, 1'b1, a, '0, '0, 1'b0);
            cycle();
            check("swept_zero", 32'(bus.rdata), 32'd0);
        end

        // 2. Low-byte write then read, latency one.
        drive(1'b1, 1'b1, 1'b0, 3, 2'b01, 16'h00A5, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 3, '0, '0, 1'b0);
        cycle();
        check("a5_rdata",  32'(bus.rdata),  32'h00A5);
        check("a5_rvalid", 32'(bus.rvalid), 32'd1);
        idle();
        cycle();
        check("a5_pulse", 32'(bus.rvalid), 32'd0);
        check("a5_hold",  32'(bus.rdata),  32'h00A5);

        // 3. Partial upper-byte overwrite.
        drive(1'b1, 1'b1, 1'b0, 5, 2'b11, 16'h1234, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 5, 2'b10, 16'hFF00, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 5, '0, '0, 1'b0);
        cycle();
        check("merge_rdata", 32'(bus.rdata), 32'hFF34);

        // 4. Same-cycle write and read: write-first.
        drive(1'b1, 1'b1, 1'b1, 7, 2'b11, 16'h003C, 1'b0);
        cycle();
        check("wf_rdata",  32'(bus.rdata),  32'h003C);
        check("wf_rvalid", 32'(bus.rvalid), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 5, 2'b01, 16'hAB77, 1'b0);
        cycle();
        check("wf_partial", 32'(bus.rdata), 32'hFF77);

        // 5. Out-of-range write and read.
        drive(1'b1, 1'b1, 1'b0, 13, 2'b11, 16'hBEEF, 1'b0);
        cycle();
        check("oor_w_err", 32'(bus.err), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 13, '0, '0, 1'b0);
        cycle();
        check("oor_r_err",    32'(bus.err),    32'd1);
        check("oor_r_rvalid", 32'(bus.rvalid), 32'd1);
        check("oor_r_rdata",  32'(bus.rdata),  32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, 1'b1, a, '0, '0, 1'b0);
            cycle();
        end
        check("oor_untouched1", 32'(bus.rdata), 32'd0);

        // 6. clr sweep, rejected read mid-sweep, reset restarts the sweep.
        drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1);
        cycle();
        check("clr_busy", 32'(bus.busy), 32'd1);
        idle();
        cycle();
        drive(1'b1, 1'b0, 1'b1, 3, '0, '0, 1'b0);
        cycle();
        check("clr_rd_err",    32'(bus.err),    32'd1);
        check("clr_rd_rvalid", 32'(bus.rvalid), 32'd0);
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        count_busy("restart_len");
        drive(1'b1, 1'b0, 1'b1, 3, '0, '0, 1'b0);
        cycle();
        check("restart_zero", 32'(bus.rdata), 32'd0);

        // Randomized traffic with occasional clr and reset.
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 15)), NB'($urandom), DW'($urandom),
                  $urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst = 1'b1;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
